// File: rtl/backend_pkg.sv
// backend_pkg: constants and types shared by the GigEx command backend.
//   CMD_LEN : default command word width in bits
//   NUM_CH  : number of GigEx user channels
//   chan_t  : GigEx channel index
package backend_pkg;

    localparam int CMD_LEN = 32;
    localparam int NUM_CH  = 8;

    typedef logic [$clog2(NUM_CH)-1:0] chan_t;

endpackage

// File: rtl/cmd_sync_fifo.sv
// cmd_sync_fifo: single-clock first-word fall-through FIFO with a registered head.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   push_i  : write din_i (ignored when full unless a pop happens in the same cycle)
//   din_i   : write data
//   full_o  : DEPTH words stored
//   pop_i   : consume the head word (ignored when empty)
//   dout_o  : head word, stable until popped
//   empty_o : no head word presented
//   free_o  : free word slots
module cmd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic                       full_o,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d, left;
    logic             valid_q, do_push, do_pop;
    logic [WIDTH-1:0] dout_q;

    always_comb begin
        full_o  = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop_i & valid_q;
        do_push = push_i & (~full_o | do_pop);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // Words already in memory after this pop; a word written this cycle
        // reaches the head register one cycle later.
        left    = cnt_q - (AW+1)'(do_pop);
        free_o  = (AW+1)'(DEPTH) - cnt_q;
        empty_o = ~valid_q;
        dout_o  = dout_q;
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= left != '0;
            if (left != '0) dout_q <= mem_q[rd_d];
        end
    end

endmodule

// File: rtl/ethernet_rx_controller.sv
// ethernet_rx_controller: GigEx Rx byte stream to buffered CMD_LEN-bit command words.
//   clk, nrst           : clock, asynchronous active-low reset
//   Q, nRx, RC          : GigEx Rx byte, active-low valid, channel
//   nRF                 : per-channel active-low Rx FIFO full back to GigEx
//   cmd_valid/ready/data: command word stream, first byte in the MSBs
//   drop_cnt            : bytes seen on other channels
//   ovf_cnt             : completed words lost to a full buffer
//   frag_cnt            : partial words dropped by idle timeout
module ethernet_rx_controller
    import backend_pkg::*;
#(
    parameter int CMD_LEN    = backend_pkg::CMD_LEN,
    parameter int RX_CHANNEL = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int SKID_WORDS = 2,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [7:0]           Q,
    input  logic                 nRx,
    input  logic [2:0]           RC,
    output logic [NUM_CH-1:0]    nRF,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [CMD_LEN-1:0]   cmd_data,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] ovf_cnt,
    output logic [CNT_WIDTH-1:0] frag_cnt
);

    localparam int NB  = CMD_LEN / 8;
    localparam int IXW = $clog2(NB + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int FW  = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]           q_q;
    logic                 nrx_q;
    chan_t                rc_q;
    logic [CMD_LEN-1:0]   word_q, word_d;
    logic [IXW-1:0]       idx_q, idx_d;
    logic [TW-1:0]        idle_q, idle_d;
    logic [CNT_WIDTH-1:0] drop_q, ovf_q, frag_q;
    logic [NUM_CH-1:0]    nrf_q, nrf_d;
    logic                 hit, miss, last, push, pop, full, empty, timeout, ovf;
    logic [FW-1:0]        free;

    always_comb begin
        hit     = ~nrx_q & (rc_q == chan_t'(RX_CHANNEL));
        miss    = ~nrx_q & ~hit;
        last    = idx_q == IXW'(NB - 1);
        push    = hit & last;
        pop     = cmd_valid & cmd_ready;
        ovf     = push & full & ~pop;
        timeout = ~hit & (idx_q != '0) & (idle_q == TW'(TIMEOUT - 1));
        word_d  = hit ? CMD_LEN'({word_q, q_q}) : word_q;
        idx_d   = hit ? (last ? '0 : idx_q + 1'b1) : (timeout ? '0 : idx_q);
        // Idle time only matters while a word is partially assembled.
        idle_d  = (hit | timeout | idx_q == '0) ? '0 : idle_q + 1'b1;
        // Unused channels are never flagged full so GigEx drains them.
        nrf_d   = '1;
        nrf_d[RX_CHANNEL] = free >= FW'(SKID_WORDS);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q_q    <= '0;
            nrx_q  <= 1'b1;
            rc_q   <= '0;
            word_q <= '0;
            idx_q  <= '0;
            idle_q <= '0;
            nrf_q  <= '0;
            drop_q <= '0;
            ovf_q  <= '0;
            frag_q <= '0;
        end else begin
            q_q    <= Q;
            nrx_q  <= nRx;
            rc_q   <= RC;
            word_q <= word_d;
            idx_q  <= idx_d;
            idle_q <= idle_d;
            nrf_q  <= nrf_d;
            if (miss && ~&drop_q) drop_q <= drop_q + 1'b1;
            if (ovf && ~&ovf_q) ovf_q <= ovf_q + 1'b1;
            if (timeout && ~&frag_q) frag_q <= frag_q + 1'b1;
        end
    end

    cmd_sync_fifo #(
        .WIDTH(CMD_LEN),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (nrst),
        .push_i (push),
        .din_i  (word_d),
        .full_o (full),
        .pop_i  (cmd_ready),
        .dout_o (cmd_data),
        .empty_o(empty),
        .free_o (free)
    );

    assign cmd_valid = ~empty;
    assign nRF       = nrf_q;
    assign drop_cnt  = drop_q;
    assign ovf_cnt   = ovf_q;
    assign frag_cnt  = frag_q;

endmodule
